// File: rtl/imm_gen_stage.sv
// imm_gen_stage: RISC-V immediate extraction feeding a 2-entry skid buffer.
// Optional CSR uimm (fmt 6) decode is enabled by defining IMM_GEN_STAGE_CSR_EN.
`default_nettype none

module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_in_instr,
  input  logic [TAG_W-1:0] i_in_tag,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [XLEN-1:0]  o_out_imm,
  output logic [2:0]       o_out_fmt,
  output logic [TAG_W-1:0] o_out_tag
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_STAGE_CSR_EN
  localparam logic [2:0] FMT_Z    = 3'd6;
`endif

  logic [31:0]      w_imm32;
  logic [XLEN-1:0]  w_imm;
  logic [2:0]       w_fmt;
  logic [1:0]       w_state_nxt;
  logic             w_push;
  logic             w_pop;

  logic [1:0]       r_state;
  logic             r_out_valid;
  logic             r_in_ready;
  logic [XLEN-1:0]  r_h_imm;
  logic [2:0]       r_h_fmt;
  logic [TAG_W-1:0] r_h_tag;
  logic [XLEN-1:0]  r_t_imm;
  logic [2:0]       r_t_fmt;
  logic [TAG_W-1:0] r_t_tag;

  // Every format fits in 32 bits sign-extended; widening to XLEN happens below.
  always_comb begin
    w_imm32 = 32'd0;
    w_fmt   = FMT_NONE;
    case (i_in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        w_fmt   = FMT_I;
        w_imm32 = {{20{i_in_instr[31]}}, i_in_instr[31:20]};
      end
      7'b0100011: begin
        w_fmt   = FMT_S;
        w_imm32 = {{20{i_in_instr[31]}}, i_in_instr[31:25], i_in_instr[11:7]};
      end
      7'b1100011: begin
        w_fmt   = FMT_B;
        w_imm32 = {{20{i_in_instr[31]}}, i_in_instr[7], i_in_instr[30:25],
                   i_in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        w_fmt   = FMT_U;
        w_imm32 = {i_in_instr[31:12], 12'd0};
      end
      7'b1101111: begin
        w_fmt   = FMT_J;
        w_imm32 = {{12{i_in_instr[31]}}, i_in_instr[19:12], i_in_instr[20],
                   i_in_instr[30:21], 1'b0};
      end
`ifdef IMM_GEN_STAGE_CSR_EN
      7'b1110011: begin
        if (i_in_instr[14]) begin
          w_fmt   = FMT_Z;
          w_imm32 = {27'd0, i_in_instr[19:15]};
        end
      end
`endif
      default: begin
        w_fmt   = FMT_NONE;
        w_imm32 = 32'd0;
      end
    endcase
  end

  generate
    if (XLEN == 64) begin : g_xlen64
      assign w_imm = {{32{w_imm32[31]}}, w_imm32};
    end else begin : g_xlen32
      assign w_imm = w_imm32;
    end
  endgenerate

  assign w_push = i_in_valid & r_in_ready;
  assign w_pop  = r_out_valid & i_out_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_push) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_push && !w_pop)      w_state_nxt = S_TWO;
          else if (!w_push && w_pop) w_state_nxt = S_EMPTY;
        end
        S_TWO:   if (w_pop) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_h_imm     <= '0;
      r_h_fmt     <= FMT_NONE;
      r_h_tag     <= '0;
      r_t_imm     <= '0;
      r_t_fmt     <= FMT_NONE;
      r_t_tag     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != S_EMPTY);
      r_in_ready  <= (w_state_nxt != S_TWO);
      if (!i_flush) begin
        // Head is the presented entry; tail only holds the skid entry in TWO.
        if ((r_state == S_EMPTY && w_push) || (r_state == S_ONE && w_push && w_pop)) begin
          r_h_imm <= w_imm;
          r_h_fmt <= w_fmt;
          r_h_tag <= i_in_tag;
        end else if (r_state == S_TWO && w_pop) begin
          r_h_imm <= r_t_imm;
          r_h_fmt <= r_t_fmt;
          r_h_tag <= r_t_tag;
        end
        if (r_state == S_ONE && w_push && !w_pop) begin
          r_t_imm <= w_imm;
          r_t_fmt <= w_fmt;
          r_t_tag <= i_in_tag;
        end
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_imm   = r_h_imm;
  assign o_out_fmt   = r_h_fmt;
  assign o_out_tag   = r_h_tag;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage: directed cases plus a randomized run
// against a queue-based reference model; a second XLEN=64 instance covers widening.
`default_nettype none

module tb_imm_gen_stage;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [31:0] tag;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic [31:0] in_tag = 32'd0;
  logic        in_ready, out_valid;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic [31:0] out_tag;

  logic        v64 = 1'b0;
  logic [31:0] instr64 = 32'd0;
  logic        in_ready64, out_valid64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic [31:0] out_tag64;

  int   nchk = 0;
  int   nerr = 0;
  ent_t q[$];
  logic [31:0] got_tags[$];

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut (
    .clk(clk), .rst(rst), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_instr(in_instr), .i_in_tag(in_tag),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_imm(out_imm), .o_out_fmt(out_fmt), .o_out_tag(out_tag)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .i_flush(1'b0),
    .i_in_valid(v64), .o_in_ready(in_ready64),
    .i_in_instr(instr64), .i_in_tag(32'h64),
    .o_out_valid(out_valid64), .i_out_ready(1'b1),
    .o_out_imm(out_imm64), .o_out_fmt(out_fmt64), .o_out_tag(out_tag64)
  );

  // Reference decode: immediates assembled by weighted field arithmetic.
  function automatic ent_t ref_dec(input logic [31:0] ins, input logic [31:0] tg, input bit x64);
    ent_t   e;
    longint v;
    v     = 0;
    e.fmt = 3'd0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: begin
        e.fmt = 3'd1;
        v = longint'(ins[30:20]) - (ins[31] ? 64'sd2048 : 64'sd0);
      end
      7'h23: begin
        e.fmt = 3'd2;
        v = longint'(ins[30:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 64'sd2048 : 64'sd0);
      end
      7'h63: begin
        e.fmt = 3'd3;
        v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2
            - (ins[31] ? 64'sd4096 : 64'sd0);
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4;
        v = longint'(ins[30:12]) * 4096 - (ins[31] ? 64'sd2147483648 : 64'sd0);
      end
      7'h6F: begin
        e.fmt = 3'd5;
        v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2
            - (ins[31] ? 64'sd1048576 : 64'sd0);
      end
`ifdef IMM_GEN_STAGE_CSR_EN
      7'h73: begin
        if (ins[14]) begin
          e.fmt = 3'd6;
          v = longint'(ins[19:15]);
        end
      end
`endif
      default: v = 0;
    endcase
    e.imm = x64 ? 64'(v) : {32'd0, 32'(v)};
    e.tag = tg;
    return e;
  endfunction

  // One cycle: drive, check against the model at negedge, then advance the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] tg,
                      input logic rdy, input logic fl);
    bit   push, pop;
    ent_t e;
    in_valid = v; in_instr = ins; in_tag = tg; out_ready = rdy; flush = fl;
    @(negedge clk);
    nchk++;
    if (out_valid !== (q.size() != 0) || in_ready !== (q.size() != 2)) begin
      nerr++;
      $display("FAIL handshake: out_valid=%0b in_ready=%0b, required %0b %0b",
               out_valid, in_ready, q.size() != 0, q.size() != 2);
    end
    if (q.size() != 0) begin
      nchk++;
      if (out_imm !== q[0].imm[31:0] || out_fmt !== q[0].fmt || out_tag !== q[0].tag) begin
        nerr++;
        $display("FAIL head: imm=%h fmt=%0d tag=%h, required imm=%h fmt=%0d tag=%h",
                 out_imm, out_fmt, out_tag, q[0].imm[31:0], q[0].fmt, q[0].tag);
      end
    end
    push = v && (q.size() < 2);
    pop  = (q.size() != 0) && rdy;
    if (pop && out_valid) got_tags.push_back(out_tag);
    e = ref_dec(ins, tg, 1'b0);
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_imm !== 32'd0 ||
        out_fmt !== 3'd0 || out_tag !== 32'd0) begin
      nerr++;
      $display("FAIL reset_state: valid=%0b ready=%0b imm=%h fmt=%0d tag=%h, required all 0",
               out_valid, in_ready, out_imm, out_fmt, out_tag);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    nchk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_release: in_ready=%0b out_valid=%0b, required 1 0", in_ready, out_valid);
    end
    q.delete();
  endtask

  task automatic test_directed_imm;
    logic [31:0] ins[4];
    logic [31:0] exp_imm[4];
    logic [2:0]  exp_fmt[4];
    ins[0] = 32'hFFF00093; exp_imm[0] = 32'hFFFFFFFF; exp_fmt[0] = 3'd1;
    ins[1] = 32'hFE000EE3; exp_imm[1] = 32'hFFFFFFFC; exp_fmt[1] = 3'd3;
    ins[2] = 32'h123450B7; exp_imm[2] = 32'h12345000; exp_fmt[2] = 3'd4;
    ins[3] = 32'h0052D073;
`ifdef IMM_GEN_STAGE_CSR_EN
    exp_imm[3] = 32'd5; exp_fmt[3] = 3'd6;
`else
    exp_imm[3] = 32'd0; exp_fmt[3] = 3'd0;
`endif
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ins[i], 32'h100 + i, 1'b1, 1'b0);
      nchk++;
      if (out_valid !== 1'b1 || out_imm !== exp_imm[i] || out_fmt !== exp_fmt[i]) begin
        nerr++;
        $display("FAIL directed_%0d: valid=%0b imm=%h fmt=%0d, required 1 imm=%h fmt=%0d",
                 i, out_valid, out_imm, out_fmt, exp_imm[i], exp_fmt[i]);
      end
    end
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_xlen64;
    @(negedge clk);
    v64 = 1'b1; instr64 = 32'h800000B7;
    @(posedge clk);
    #1;
    v64 = 1'b0;
    nchk++;
    if (out_valid64 !== 1'b1 || out_imm64 !== 64'hFFFFFFFF80000000 || out_fmt64 !== 3'd4) begin
      nerr++;
      $display("FAIL xlen64_u: valid=%0b imm=%h fmt=%0d, required 1 imm=ffffffff80000000 fmt=4",
               out_valid64, out_imm64, out_fmt64);
    end
  endtask

  task automatic test_backpressure;
    got_tags.delete();
    step(1'b1, 32'h00100093, 32'd1, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 32'd2, 1'b0, 1'b0);
    nchk++;
    if (in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL bp_full: in_ready=%0b, required 0", in_ready);
    end
    step(1'b1, 32'h00300093, 32'd3, 1'b0, 1'b0);
    step(1'b1, 32'h00300093, 32'd3, 1'b1, 1'b0);
    step(1'b1, 32'h00300093, 32'd3, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    nchk++;
    if (got_tags.size() != 3 || got_tags[0] !== 32'd1 || got_tags[1] !== 32'd2 ||
        got_tags[2] !== 32'd3) begin
      nerr++;
      $display("FAIL bp_order: got %0d tags (%p), required 1 2 3", got_tags.size(), got_tags);
    end
  endtask

  task automatic test_flush;
    step(1'b1, 32'h00A00093, 32'd10, 1'b0, 1'b0);
    step(1'b1, 32'h00B00093, 32'd11, 1'b0, 1'b0);
    step(1'b1, 32'h00C00093, 32'd99, 1'b0, 1'b1);
    nchk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL flush: out_valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
    end
    got_tags.delete();
    repeat (3) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    nchk++;
    if (got_tags.size() != 0) begin
      nerr++;
      $display("FAIL flush_drop: %0d entries emerged after flush, required 0", got_tags.size());
    end
  endtask

  task automatic test_random;
    logic [6:0] ops[11];
    logic [31:0] ins;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F};
    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 10)];
      step($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0);
    end
  endtask

  task automatic test_reset_midflight;
    step(1'b1, 32'h00500093, 32'd55, 1'b0, 1'b0);
    step(1'b1, 32'h00600093, 32'd56, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    nchk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_imm !== 32'd0 ||
        out_fmt !== 3'd0 || out_tag !== 32'd0) begin
      nerr++;
      $display("FAIL async_reset: valid=%0b ready=%0b imm=%h fmt=%0d tag=%h, required all 0",
               out_valid, in_ready, out_imm, out_fmt, out_tag);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    got_tags.delete();
    repeat (3) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    nchk++;
    if (got_tags.size() != 0) begin
      nerr++;
      $display("FAIL reset_loss: %0d stale entries emerged, required 0", got_tags.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed_imm();
    test_xlen64();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

`default_nettype wire
